// File: rtl/bcd_scan_controller_if.sv
// Producer-to-display handshake bundle for bcd_scan_controller.
// The master offers a 14-bit binary value and the slave returns in_ready.
interface bcd_scan_controller_if;
  logic        in_valid;
  logic [13:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bcd_scan_controller.sv
// Binary-to-BCD converter (shift-and-add-3) feeding a 4-digit multiplexed display scanner.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_scan_controller #(
  parameter int SCAN_DIV_W = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_scan_controller_if.slave  in_if,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [3:0]            digit,
  output logic [1:0]            an_sel,
  output logic                  blank
);

  typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, LOAD} state_t;

  state_t           state_q;
  logic [29:0]      work_q;
  logic [3:0]       cnt_q;
  logic             done_q;
  logic             ovf_q;
  logic [3:0]       held_q [4];

  logic [13:0]      sat_val;
  logic [29:0]      work_adj;
  logic [3:0]       cnt_inc;

  assign sat_val = (in_if.in_data > 14'd9999) ? 14'd9999 : in_if.in_data;
  assign cnt_inc = cnt_q + 4'd1;
  assign work_adj[13:0] = work_q[13:0];

  // Add 3 to every BCD nibble that would overflow past 9 after the next doubling.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = work_q[14 + 4*gi +: 4];
      assign work_adj[14 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 4; i++) held_q[i] <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_if.in_valid) begin
            work_q  <= {16'd0, sat_val};
            cnt_q   <= 4'd0;
            ovf_q   <= (in_if.in_data > 14'd9999);
            state_q <= ADJUST;
          end
        end
        ADJUST: begin
          work_q  <= work_adj;
          state_q <= SHIFT;
        end
        SHIFT: begin
          work_q  <= {work_q[28:0], 1'b0};
          cnt_q   <= cnt_inc;
          state_q <= (cnt_inc < 4'd14) ? ADJUST : LOAD;
        end
        LOAD: begin
          for (int i = 0; i < 4; i++) held_q[i] <= work_q[14 + 4*i +: 4];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign ovf            = ovf_q;

  // Anode scanner: free-running, independent of the conversion FSM.
  logic [SCAN_DIV_W-1:0] presc_q, presc_d;
  logic [1:0]            an_sel_q, an_sel_d;
  logic [3:0]            digit_q, digit_d;

  always_comb begin
    presc_d  = presc_q + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
    an_sel_d = (presc_d == '0) ? an_sel_q + 2'd1 : an_sel_q;
    digit_d  = held_q[an_sel_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      an_sel_q <= 2'd0;
      digit_q  <= 4'd0;
    end else begin
      presc_q  <= presc_d;
      an_sel_q <= an_sel_d;
      digit_q  <= digit_d;
    end
  end

  assign an_sel = an_sel_q;
  assign digit  = digit_q;

`ifdef LEADING_ZERO_BLANK_EN
  // lz[i]: digit i and every higher digit are zero; the ones digit is never blanked.
  logic [3:0] lz;
  logic       blank_q, blank_d;

  assign lz[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      if (gi == 3) begin : g_top
        assign lz[gi] = (held_q[gi] == 4'd0);
      end else begin : g_low
        assign lz[gi] = (held_q[gi] == 4'd0) && lz[gi+1];
      end
    end
  endgenerate

  always_comb begin
    blank_d = lz[an_sel_q];
  end

  always_ff @(posedge clk) begin
    if (reset) blank_q <= 1'b0;
    else       blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Directed bench for bcd_scan_controller with an arithmetic reference model checked every cycle.
// Build with LEADING_ZERO_BLANK_EN defined to also exercise leading-zero blanking.
module tb_bcd_scan_controller;
  localparam int W = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy, done, ovf, blank;
  logic [3:0] digit;
  logic [1:0] an_sel;

  always #5 clk = ~clk;

  bcd_scan_controller_if bus ();

  bcd_scan_controller #(.SCAN_DIV_W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .in_if  (bus),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .digit  (digit),
    .an_sel (an_sel),
    .blank  (blank)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pw10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Reference model: the display shows a decimal integer; conversion takes a fixed 29 edges after accept.
  int m_n = 0, m_left = 0, m_shown = 0, m_val = 0, m_digit = 0;
  bit m_ovf = 0, m_done = 0, m_blank = 0, m_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_n <= 0; m_left <= 0; m_shown <= 0; m_ovf <= 0;
      m_done <= 0; m_digit <= 0; m_blank <= 0; m_live <= 1;
    end else begin
      m_n     <= m_n + 1;
      m_digit <= (m_shown / pw10((m_n / (1 << W)) % 4)) % 10;
      m_blank <= LZB && ((m_n / (1 << W)) % 4 != 0) && (m_shown < pw10((m_n / (1 << W)) % 4));
      m_done  <= (m_left == 1);
      if (m_left == 0) begin
        if (bus.in_valid) begin
          m_left <= 29;
          m_val  <= (int'(bus.in_data) > 9999) ? 9999 : int'(bus.in_data);
          m_ovf  <= (int'(bus.in_data) > 9999);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) m_shown <= m_val;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", int'(bus.in_ready), int'(m_left == 0));
      check("busy",     int'(busy),         int'(m_left != 0));
      check("done",     int'(done),         int'(m_done));
      check("ovf",      int'(ovf),          int'(m_ovf));
      check("an_sel",   int'(an_sel),       (m_n / (1 << W)) % 4);
      check("digit",    int'(digit),        m_digit);
      check("blank",    int'(blank),        int'(m_blank));
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 14'(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts edges with the accept edge as the first; done must appear after the 30th.
  task automatic wait_done(input string name);
    int n = 1;
    while (n <= 40) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
    check(name, n, 30);
  endtask

  task automatic show_digit(input int k, input int d, input bit b);
    int guard = 0;
    @(negedge clk);
    while (int'(an_sel) != k && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("an_sel_reach_%0d", k), int'(an_sel), k);
    @(negedge clk);
    check($sformatf("digit_at_%0d", k), int'(digit), d);
    check($sformatf("blank_at_%0d", k), int'(blank), int'(LZB && b));
  endtask

  task automatic count_done(input string name, input int cycles, input int exp);
    int cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check(name, cnt, exp);
  endtask

  initial begin
    int guard;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 14'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_busy",     int'(busy), 0);
    check("rst_done",     int'(done), 0);
    check("rst_ovf",      int'(ovf), 0);
    check("rst_digit",    int'(digit), 0);
    check("rst_an_sel",   int'(an_sel), 0);
    check("rst_blank",    int'(blank), 0);
    reset = 1'b0;

    send(1234);
    wait_done("latency_1234");
    check("ovf_1234", int'(ovf), 0);
    show_digit(0, 4, 1'b0);
    show_digit(1, 3, 1'b0);
    show_digit(2, 2, 1'b0);
    show_digit(3, 1, 1'b0);

    // an_sel must leave 3 for 0 exactly 4 clocks after reaching it.
    guard = 0;
    while (!(int'(an_sel) == 3) && guard < 40) begin @(negedge clk); guard++; end
    @(negedge clk);
    while (int'(an_sel) == 3 && guard < 40) begin @(negedge clk); guard++; end
    check("an_sel_wrap", int'(an_sel), 0);
    check("digit_lags_wrap", int'(digit), 1);

    send(12000);
    wait_done("latency_12000");
    check("ovf_12000", int'(ovf), 1);
    show_digit(0, 9, 1'b0);
    show_digit(3, 9, 1'b0);
    send(5);
    wait_done("latency_5");
    check("ovf_5", int'(ovf), 0);

    // Busy: in_valid held with changing data must not start a second conversion.
    send(100);
    repeat (20) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 14'($urandom_range(0, 16383));
    end
    check("busy_ready_low", int'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    count_done("single_done", 40, 1);
    show_digit(2, 1, 1'b0);
    show_digit(0, 0, 1'b0);

    // Reset during conversion aborts it and clears the display.
    send(4321);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", int'(bus.in_ready), 1);
    count_done("abort_no_done", 40, 0);
    show_digit(3, 0, 1'b1);
    show_digit(0, 0, 1'b0);

    send(7);
    wait_done("latency_7");
    show_digit(3, 0, 1'b1);
    show_digit(2, 0, 1'b1);
    show_digit(1, 0, 1'b1);
    show_digit(0, 7, 1'b0);

    send(0);
    wait_done("latency_0");
    show_digit(1, 0, 1'b1);
    show_digit(0, 0, 1'b0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
